// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM generators and the setpoint ramp controller.
// Lengths are in microseconds throughout.
package pwm_pkg;

    localparam int LEN_W         = 16;
    localparam int DEF_CLK_DIV   = 50;
    localparam int DEF_FRAME_US  = 10000;
    localparam int DEF_LEN_MIN   = 500;
    localparam int DEF_LEN_MAX   = 2500;
    localparam int DEF_RESET_LEN = 1500;

    typedef logic [LEN_W-1:0] len_t;

    function automatic len_t clamp_len(input len_t v, input len_t lo, input len_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // One frame's slew of len toward tgt; inputs are clamped, so 17 signed bits cannot overflow.
    function automatic len_t ramp_step(input len_t len, input len_t tgt, input len_t step);
        logic signed [LEN_W:0] d;
        logic        [LEN_W:0] mag;
        d   = $signed({1'b0, tgt}) - $signed({1'b0, len});
        mag = d[LEN_W] ? $unsigned(-d) : $unsigned(d);
        if (mag <= {1'b0, step}) return tgt;
        if (!d[LEN_W])           return len + step;
        return len - step;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Synchronous-reset prescaler: one-cycle tick every CLK_DIV clocks, replacing derived clocks.
module us_tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk0,
    input  logic rst,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        tick      = (div_cnt_q == CW'(CLK_DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk0) begin
        if (rst) div_cnt_q <= '0;
        else     div_cnt_q <= div_cnt_d;
    end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Multi-channel servo setpoint controller: slews each channel's PWM length toward its
// written target by at most STEP microseconds once per PWM frame.
module servo_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int FRAME_US  = DEF_FRAME_US,
    parameter int STEP      = 10,
    parameter int LEN_MIN   = DEF_LEN_MIN,
    parameter int LEN_MAX   = DEF_LEN_MAX,
    parameter int RESET_LEN = DEF_RESET_LEN
) (
    input  logic                  clk0,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [2:0]            wr_ch,
    input  logic [LEN_W-1:0]      wr_data,
    input  logic                  freeze,
    output logic [LEN_W*N_CH-1:0] len_bus,
    output logic [N_CH-1:0]       at_target,
    output logic                  frame_start
);

    localparam int UW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

    logic          tick;
    logic          frame_evt;
    logic          ramp_en;
    len_t          wr_clamped;
    logic [UW-1:0] us_cnt_q, us_cnt_d;
    logic          frame_start_q, frame_start_d;

    us_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk0 (clk0),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        frame_evt = tick && (us_cnt_q == UW'(FRAME_US - 1));
        us_cnt_d  = us_cnt_q;
        if (tick) us_cnt_d = frame_evt ? '0 : us_cnt_q + 1'b1;
        frame_start_d = frame_evt;
        ramp_en       = frame_evt && !freeze;
        wr_clamped    = clamp_len(wr_data, len_t'(LEN_MIN), len_t'(LEN_MAX));
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            us_cnt_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            us_cnt_q      <= us_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        len_t len_q, len_d;
        len_t tgt_q, tgt_d;

        // Ramp reads tgt_q, so a write on a frame edge only takes effect next frame.
        always_comb begin
            len_d = ramp_en ? ramp_step(len_q, tgt_q, len_t'(STEP)) : len_q;
            tgt_d = (wr_en && (wr_ch == 3'(i))) ? wr_clamped : tgt_q;
        end

        always_ff @(posedge clk0) begin
            if (rst) begin
                len_q <= len_t'(RESET_LEN);
                tgt_q <= len_t'(RESET_LEN);
            end else begin
                len_q <= len_d;
                tgt_q <= tgt_d;
            end
        end

        assign len_bus[LEN_W*i +: LEN_W] = len_q;
        assign at_target[i]              = (len_q == tgt_q);
    end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Self-checking bench for servo_ramp_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against an arithmetic reference model.
module tb_servo_ramp_ctrl;

    localparam int N_CH      = 4;
    localparam int CLK_DIV   = 5;
    localparam int FRAME_US  = 4;
    localparam int STEP      = 10;
    localparam int LEN_MIN   = 500;
    localparam int LEN_MAX   = 2500;
    localparam int RESET_LEN = 1500;
    localparam int PERIOD    = CLK_DIV * FRAME_US;

    logic               clk0    = 1'b0;
    logic               rst     = 1'b1;
    logic               wr_en   = 1'b0;
    logic [2:0]         wr_ch   = '0;
    logic [15:0]        wr_data = '0;
    logic               freeze  = 1'b0;
    logic [16*N_CH-1:0] len_bus;
    logic [N_CH-1:0]    at_target;
    logic               frame_start;

    int total = 0;
    int bad   = 0;
    int tcyc  = 0;

    int m_len [N_CH];
    int m_tgt [N_CH];
    int m_cyc   = 0;
    bit m_fs    = 1'b0;
    bit m_valid = 1'b0;

    always #5 clk0 = ~clk0;

    servo_ramp_ctrl #(
        .N_CH      (N_CH),
        .CLK_DIV   (CLK_DIV),
        .FRAME_US  (FRAME_US),
        .STEP      (STEP),
        .LEN_MIN   (LEN_MIN),
        .LEN_MAX   (LEN_MAX),
        .RESET_LEN (RESET_LEN)
    ) dut (
        .clk0        (clk0),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .freeze      (freeze),
        .len_bus     (len_bus),
        .at_target   (at_target),
        .frame_start (frame_start)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_ch(input string name, input int ch, input int exp);
        check(name, 64'(len_bus[16*ch +: 16]), 64'(exp));
    endtask

    task automatic step();
        @(negedge clk0);
        tcyc++;
    endtask

    task automatic wait_until(input int c);
        while (tcyc < c) step();
    endtask

    task automatic write(input int ch, input int data);
        wr_en   = 1'b1;
        wr_ch   = 3'(ch);
        wr_data = 16'(data);
        step();
        wr_en   = 1'b0;
    endtask

    // Reference model: cycle index since reset, frame every PERIOD cycles, plain integer slewing.
    always @(posedge clk0) begin : model
        bit evt;
        int d;
        int v;
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                m_len[c] = RESET_LEN;
                m_tgt[c] = RESET_LEN;
            end
            m_cyc   = 0;
            m_fs    = 1'b0;
            m_valid = 1'b1;
        end else begin
            evt = ((m_cyc + 1) % PERIOD) == 0;
            if (evt && !freeze) begin
                for (int c = 0; c < N_CH; c++) begin
                    d = m_tgt[c] - m_len[c];
                    if (d <= STEP && d >= -STEP) m_len[c] = m_tgt[c];
                    else if (d > 0)              m_len[c] = m_len[c] + STEP;
                    else                         m_len[c] = m_len[c] - STEP;
                end
            end
            if (wr_en && int'(wr_ch) < N_CH) begin
                v = int'(wr_data);
                m_tgt[wr_ch] = (v < LEN_MIN) ? LEN_MIN : (v > LEN_MAX) ? LEN_MAX : v;
            end
            m_fs = evt;
            m_cyc++;
        end
    end

    always @(negedge clk0) begin : compare
        logic [16*N_CH-1:0] exp_bus;
        logic [N_CH-1:0]    exp_at;
        if (m_valid) begin
            for (int c = 0; c < N_CH; c++) begin
                exp_bus[16*c +: 16] = 16'(m_len[c]);
                exp_at[c]           = (m_len[c] == m_tgt[c]);
            end
            check("model_len_bus", 64'(len_bus), 64'(exp_bus));
            check("model_at_target", 64'(at_target), 64'(exp_at));
            check("model_frame_start", 64'(frame_start), 64'(m_fs));
        end
    end

    initial begin
        repeat (3) @(negedge clk0);
        rst  = 1'b0;
        tcyc = 0;
        check("reset_len", 64'(len_bus), {4{16'd1500}});
        check("reset_at_target", 64'(at_target), 64'h f);
        check("reset_frame_start", 64'(frame_start), 64'h0);

        for (int k = 1; k <= 100; k++) begin
            step();
            check("idle_frame_start", 64'(frame_start), 64'((tcyc % 20) == 0));
        end
        check("idle_len", 64'(len_bus), {4{16'd1500}});
        check("idle_at_target", 64'(at_target), 64'h f);

        write(0, 1530);
        check("wr_at_target", 64'(at_target), 64'b1110);
        wait_until(119); check_ch("ch0_pre", 0, 1500);
        wait_until(120); check_ch("ch0_f1", 0, 1510);
        check("ch0_f1_fs", 64'(frame_start), 64'h1);
        wait_until(140); check_ch("ch0_f2", 0, 1520);
        wait_until(159); check("ch0_f2_at", 64'(at_target), 64'b1110);
        wait_until(160); check_ch("ch0_f3", 0, 1530);
        check("ch0_f3_at", 64'(at_target), 64'b1111);

        wait_until(179);
        write(3, 1600);
        check_ch("simul_hold", 3, 1500);
        check("simul_at", 64'(at_target), 64'b0111);
        check("simul_fs", 64'(frame_start), 64'h1);
        wait_until(200); check_ch("simul_next", 3, 1510);

        write(1, 3000);
        write(2, 100);
        write(6, 1234);
        write(4, 1234);
        check("clamp_at", 64'(at_target), 64'b0001);

        freeze = 1'b1;
        wait_until(220);
        check_ch("frz_f1", 3, 1510);
        check("frz_f1_fs", 64'(frame_start), 64'h1);
        wait_until(240);
        check_ch("frz_f2_ch3", 3, 1510);
        check_ch("frz_f2_ch1", 1, 1500);
        check("frz_f2_fs", 64'(frame_start), 64'h1);
        wait_until(250);
        freeze = 1'b0;
        wait_until(260);
        check_ch("resume_ch3", 3, 1520);
        check_ch("resume_ch1", 1, 1510);
        check_ch("resume_ch2", 2, 1490);

        wait_until(2239); check_ch("settle_pre", 1, 2490);
        wait_until(2240); check_ch("settle_max", 1, 2500);
        check_ch("settle_min", 2, 500);
        wait_until(2260);
        check("settled_bus", 64'(len_bus), {16'd1600, 16'd500, 16'd2500, 16'd1530});
        check("settled_at", 64'(at_target), 64'h f);

        write(0, 2000);
        wait_until(2300); check_ch("midramp", 0, 1550);
        wait_until(2305);
        rst = 1'b1;
        step();
        rst  = 1'b0;
        tcyc = 0;
        check("rst_mid_len", 64'(len_bus), {4{16'd1500}});
        check("rst_mid_at", 64'(at_target), 64'h f);
        check("rst_mid_fs", 64'(frame_start), 64'h0);
        for (int k = 1; k <= 21; k++) begin
            step();
            check("rst_fs_timing", 64'(frame_start), 64'(tcyc == 20));
        end

        for (int k = 0; k < 3000; k++) begin
            wr_en = ($urandom_range(0, 3) == 0);
            wr_ch = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) wr_data = 16'($urandom_range(0, 3500));
            else                           wr_data = 16'(1500 + $urandom_range(0, 24) - 12);
            if ($urandom_range(0, 199) == 0) freeze = ~freeze;
            rst = ($urandom_range(0, 699) == 0);
            step();
        end
        wr_en  = 1'b0;
        rst    = 1'b0;
        freeze = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
